// File: rtl/minimig_reset_sequencer_pkg.sv
// Shared types and defaults for the Minimig reset sequencer: FSM state
// encoding, reset-cause codes and the default timing parameters.
package minimig_reset_pkg;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_PERIPH = 2'd1,
        ST_RUN    = 2'd2,
        ST_INSTR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'd0,
        CAUSE_HOST = 2'd1,
        CAUSE_KBD  = 2'd2,
        CAUSE_BOOT = 2'd3
    } cause_t;

    localparam int unsigned CNT_W            = 8;
    localparam int unsigned HOLD_TICKS_DEF   = 4;
    localparam int unsigned CPU_DELAY_DEF    = 2;
    localparam int unsigned INSTR_CYCLES_DEF = 124;

    // Host beats keyboard beats boot_done when several requests coincide.
    function automatic cause_t pick_cause(input logic host_req,
                                          input logic kbd_req,
                                          input logic boot_req);
        cause_t c;
        c = CAUSE_POR;
        if (host_req)
            c = CAUSE_HOST;
        else if (kbd_req)
            c = CAUSE_KBD;
        else if (boot_req)
            c = CAUSE_BOOT;
        return c;
    endfunction

endpackage

// File: rtl/minimig_reset_sequencer_if.sv
// Request/response bundle between the reset sources/consumers and the
// reset sequencer. The sequencer is the slave: it samples the requests and
// drives the staged reset outputs.
interface minimig_reset_sequencer_if;

    logic       clk7_en;
    logic       cnt;
    logic       mrst;
    logic       kbd_rst;
    logic       boot_done;
    logic       cpu_rst_instr;
    logic       sys_reset;
    logic       cpu_reset;
    logic       boot;
    logic [1:0] cause;
    logic       busy;

    modport master (
        output clk7_en, cnt, mrst, kbd_rst, boot_done, cpu_rst_instr,
        input  sys_reset, cpu_reset, boot, cause, busy
    );

    modport slave (
        input  clk7_en, cnt, mrst, kbd_rst, boot_done, cpu_rst_instr,
        output sys_reset, cpu_reset, boot, cause, busy
    );

endinterface

// File: rtl/minimig_reset_sequencer.sv
// Central Minimig reset controller. Full requests (host, keyboard, boot
// done) restart a HOLD -> PERIPH -> RUN sequence timed in cnt ticks; the
// 68000 RESET instruction gives a peripheral-only pulse timed in clk7_en
// cycles. One shared saturating counter serves every timed state.
module minimig_reset_sequencer
    import minimig_reset_pkg::*;
#(
    parameter int unsigned HOLD_TICKS   = HOLD_TICKS_DEF,
    parameter int unsigned CPU_DELAY    = CPU_DELAY_DEF,
    parameter int unsigned INSTR_CYCLES = INSTR_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     _rst,
    minimig_reset_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] DELAY_LIM = CNT_W'(CPU_DELAY);
    // The entry enable is itself the first INSTR cycle, hence the -1.
    localparam logic [CNT_W-1:0] INSTR_LIM = CNT_W'(INSTR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sys_reset_q, sys_reset_d;
    logic             cpu_reset_q, cpu_reset_d;
    logic             boot_q, boot_d;
    cause_t           cause_q, cause_d;
    logic             busy_q, busy_d;

    logic             full_req;
    logic [CNT_W-1:0] count_inc;

    assign full_req  = bus.mrst | bus.kbd_rst | bus.boot_done;
    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;

    // State and output registers; _rst restores the power-on values at once.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q     <= ST_HOLD;
            count_q     <= '0;
            sys_reset_q <= 1'b1;
            cpu_reset_q <= 1'b1;
            boot_q      <= 1'b1;
            cause_q     <= CAUSE_POR;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sys_reset_q <= sys_reset_d;
            cpu_reset_q <= cpu_reset_d;
            boot_q      <= boot_d;
            cause_q     <= cause_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: nothing moves unless clk7_en is high; a full request
    // overrides whatever the current state would otherwise do.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sys_reset_d = sys_reset_q;
        cpu_reset_d = cpu_reset_q;
        boot_d      = boot_q;
        cause_d     = cause_q;

        if (bus.clk7_en) begin
            if (full_req) begin
                state_d     = ST_HOLD;
                count_d     = '0;
                sys_reset_d = 1'b1;
                cpu_reset_d = 1'b1;
                cause_d     = pick_cause(bus.mrst, bus.kbd_rst, bus.boot_done);
                // Once the boot ROM has finished it stays unmapped until _rst.
                if (bus.boot_done)
                    boot_d = 1'b0;
            end else begin
                unique case (state_q)
                    ST_HOLD: begin
                        if (count_q == HOLD_LIM) begin
                            state_d     = ST_PERIPH;
                            count_d     = '0;
                            sys_reset_d = 1'b0;
                        end else if (bus.cnt) begin
                            count_d = count_inc;
                        end
                    end
                    ST_PERIPH: begin
                        if (count_q == DELAY_LIM) begin
                            state_d     = ST_RUN;
                            count_d     = '0;
                            cpu_reset_d = 1'b0;
                        end else if (bus.cnt) begin
                            count_d = count_inc;
                        end
                    end
                    ST_RUN: begin
                        if (bus.cpu_rst_instr) begin
                            state_d     = ST_INSTR;
                            count_d     = '0;
                            sys_reset_d = 1'b1;
                        end
                    end
                    ST_INSTR: begin
                        // Further RESET instructions here do not restart the pulse.
                        if (count_q == INSTR_LIM) begin
                            state_d     = ST_RUN;
                            count_d     = '0;
                            sys_reset_d = 1'b0;
                        end else begin
                            count_d = count_inc;
                        end
                    end
                    default: state_d = ST_HOLD;
                endcase
            end
        end

        busy_d = (state_d != ST_RUN);
    end

    assign bus.sys_reset = sys_reset_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.boot      = boot_q;
    assign bus.cause     = cause_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_minimig_reset_sequencer.sv
// Directed bench for the Minimig reset sequencer: power-on, host, keyboard,
// boot-done and RESET-instruction sequences plus request collisions and an
// asynchronous _rst in the middle of PERIPH.
module tb_minimig_reset_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    minimig_reset_sequencer_if bus_if ();

    minimig_reset_sequencer #(
        .HOLD_TICKS   (4),
        .CPU_DELAY    (2),
        .INSTR_CYCLES (124)
    ) dut (
        .clk  (clk),
        ._rst (rst_n),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // One enable cycle followed by one disabled cycle; cnt is also held high
    // during the disabled cycle so a count outside clk7_en would show up.
    task automatic tick_en(input logic c);
        bus_if.clk7_en = 1'b1;
        bus_if.cnt     = c;
        @(posedge clk);
        #1;
        bus_if.clk7_en = 1'b0;
        bus_if.cnt     = c;
        @(posedge clk);
        #1;
        bus_if.cnt     = 1'b0;
    endtask

    // Eight enables with cnt on the last one.
    task automatic cnt_tick();
        repeat (7) tick_en(1'b0);
        tick_en(1'b1);
    endtask

    // From HOLD with the counter at 0 and no request: walk through to RUN.
    task automatic release_seq(input string pfx);
        repeat (3) cnt_tick();
        check_val({pfx, "_sys_after3"}, 8'(bus_if.sys_reset), 8'd1);
        cnt_tick();
        check_val({pfx, "_sys_after4"}, 8'(bus_if.sys_reset), 8'd1);
        tick_en(1'b0);
        check_val({pfx, "_sys_fall"}, 8'(bus_if.sys_reset), 8'd0);
        check_val({pfx, "_cpu_periph"}, 8'(bus_if.cpu_reset), 8'd1);
        check_val({pfx, "_busy_periph"}, 8'(bus_if.busy), 8'd1);
        cnt_tick();
        cnt_tick();
        check_val({pfx, "_cpu_after2"}, 8'(bus_if.cpu_reset), 8'd1);
        tick_en(1'b0);
        check_val({pfx, "_cpu_fall"}, 8'(bus_if.cpu_reset), 8'd0);
        check_val({pfx, "_busy_run"}, 8'(bus_if.busy), 8'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        bus_if.clk7_en       = 1'b0;
        bus_if.cnt           = 1'b0;
        bus_if.mrst          = 1'b0;
        bus_if.kbd_rst       = 1'b0;
        bus_if.boot_done     = 1'b0;
        bus_if.cpu_rst_instr = 1'b0;

        // Reset before the first clock edge: values appear asynchronously.
        #1 rst_n = 1'b0;
        #2;
        check_val("rst_sys",   8'(bus_if.sys_reset), 8'd1);
        check_val("rst_cpu",   8'(bus_if.cpu_reset), 8'd1);
        check_val("rst_boot",  8'(bus_if.boot),      8'd1);
        check_val("rst_cause", 8'(bus_if.cause),     8'd0);
        check_val("rst_busy",  8'(bus_if.busy),      8'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Power-on sequence.
        release_seq("por");
        check_val("por_boot",  8'(bus_if.boot),  8'd1);
        check_val("por_cause", 8'(bus_if.cause), 8'd0);

        // Host reset held for 10 cnt ticks (cnt coincides with the request).
        bus_if.mrst = 1'b1;
        repeat (10) cnt_tick();
        check_val("host_sys_held",  8'(bus_if.sys_reset), 8'd1);
        check_val("host_cpu_held",  8'(bus_if.cpu_reset), 8'd1);
        check_val("host_cause",     8'(bus_if.cause),     8'd1);
        check_val("host_busy",      8'(bus_if.busy),      8'd1);
        bus_if.mrst = 1'b0;
        release_seq("host");
        check_val("host_boot", 8'(bus_if.boot), 8'd1);

        // Boot done clears boot on the next enable.
        bus_if.boot_done = 1'b1;
        tick_en(1'b0);
        bus_if.boot_done = 1'b0;
        check_val("bd_boot",  8'(bus_if.boot),      8'd0);
        check_val("bd_cause", 8'(bus_if.cause),     8'd3);
        check_val("bd_sys",   8'(bus_if.sys_reset), 8'd1);
        check_val("bd_cpu",   8'(bus_if.cpu_reset), 8'd1);
        release_seq("bd");
        bus_if.mrst = 1'b1;
        tick_en(1'b0);
        bus_if.mrst = 1'b0;
        check_val("bd_host_boot",  8'(bus_if.boot),  8'd0);
        check_val("bd_host_cause", 8'(bus_if.cause), 8'd1);
        release_seq("bd_host");

        // RESET instruction: 124 enables of sys_reset; second pulse ignored.
        bus_if.cpu_rst_instr = 1'b1;
        tick_en(1'b0);
        bus_if.cpu_rst_instr = 1'b0;
        check_val("ins_sys_rise", 8'(bus_if.sys_reset), 8'd1);
        check_val("ins_cpu_rise", 8'(bus_if.cpu_reset), 8'd0);
        check_val("ins_busy",     8'(bus_if.busy),      8'd1);
        for (int i = 1; i <= 123; i++) begin
            if (i == 50)
                bus_if.cpu_rst_instr = 1'b1;
            tick_en(1'b0);
            bus_if.cpu_rst_instr = 1'b0;
        end
        check_val("ins_sys_123", 8'(bus_if.sys_reset), 8'd1);
        check_val("ins_cpu_123", 8'(bus_if.cpu_reset), 8'd0);
        tick_en(1'b0);
        check_val("ins_sys_fall",  8'(bus_if.sys_reset), 8'd0);
        check_val("ins_busy_done", 8'(bus_if.busy),      8'd0);
        check_val("ins_cause",     8'(bus_if.cause),     8'd1);

        // Keyboard request during INSTR.
        bus_if.cpu_rst_instr = 1'b1;
        tick_en(1'b0);
        bus_if.cpu_rst_instr = 1'b0;
        repeat (10) tick_en(1'b0);
        bus_if.kbd_rst = 1'b1;
        tick_en(1'b0);
        bus_if.kbd_rst = 1'b0;
        check_val("kbd_sys",   8'(bus_if.sys_reset), 8'd1);
        check_val("kbd_cpu",   8'(bus_if.cpu_reset), 8'd1);
        check_val("kbd_cause", 8'(bus_if.cause),     8'd2);
        check_val("kbd_busy",  8'(bus_if.busy),      8'd1);

        // Host and keyboard together: host wins.
        bus_if.mrst    = 1'b1;
        bus_if.kbd_rst = 1'b1;
        tick_en(1'b1);
        bus_if.mrst    = 1'b0;
        bus_if.kbd_rst = 1'b0;
        check_val("both_cause", 8'(bus_if.cause), 8'd1);
        release_seq("both");

        // Full request and RESET instruction on the same enable: HOLD.
        bus_if.kbd_rst       = 1'b1;
        bus_if.cpu_rst_instr = 1'b1;
        tick_en(1'b0);
        bus_if.kbd_rst       = 1'b0;
        bus_if.cpu_rst_instr = 1'b0;
        check_val("coll_cpu",   8'(bus_if.cpu_reset), 8'd1);
        check_val("coll_cause", 8'(bus_if.cause),     8'd2);
        check_val("coll_busy",  8'(bus_if.busy),      8'd1);

        // _rst in the middle of PERIPH, away from any clock edge.
        repeat (4) cnt_tick();
        tick_en(1'b0);
        check_val("mid_sys_periph", 8'(bus_if.sys_reset), 8'd0);
        cnt_tick();
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_sys",   8'(bus_if.sys_reset), 8'd1);
        check_val("mid_cpu",   8'(bus_if.cpu_reset), 8'd1);
        check_val("mid_boot",  8'(bus_if.boot),      8'd1);
        check_val("mid_cause", 8'(bus_if.cause),     8'd0);
        check_val("mid_busy",  8'(bus_if.busy),      8'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/minimig_reset_sequencer.md
# minimig_reset_sequencer

Central reset controller for the Minimig core: arbitrates reset requests from the host/OSD, the keyboard, the boot ROM "boot done" strobe and the 68000 RESET instruction, and sequences staged peripheral and CPU reset outputs. It also owns the boot-ROM mapping flag consumed by Gary. It sits between the request sources and every block that consumes `sys_reset`/`cpu_reset`. All timing advances only on `clk7_en`.

## Interface
Parameters:
- `HOLD_TICKS`, 4: `cnt` pulses that both resets stay asserted after the last full request drops.
- `CPU_DELAY`, 2: `cnt` pulses between `sys_reset` release and `cpu_reset` release.
- `INSTR_CYCLES`, 124: `clk7_en` cycles of peripheral-only reset for the 68000 RESET instruction.

Ports:
- `clk`  in  1: bus clock; all state changes on its rising edge.
- `_rst`  in  1: reset, asynchronous and active-low.
- `clk7_en`  in  1: 7 MHz enable; sampling and state updates only when high.
- `cnt`  in  1: slow tick (one per video line) for hold timing.
- `mrst`  in  1: host/OSD reset request, level.
- `kbd_rst`  in  1: keyboard Ctrl-Amiga-Amiga request, level.
- `boot_done`  in  1: boot ROM strobe (both CIAs selected), level.
- `cpu_rst_instr`  in  1: 68000 RESET instruction, pulse.
- `sys_reset`  out  1: peripheral reset, active-high.
- `cpu_reset`  out  1: CPU reset, active-high.
- `boot`  out  1: boot-ROM mapping enable.
- `cause`  out  2: last full-reset cause: 0 = power-on, 1 = host, 2 = keyboard, 3 = boot_done.
- `busy`  out  1: high whenever state is not RUN.

## Operation
- States: HOLD, PERIPH, RUN, INSTR.
- On `_rst` low, all outputs take these values immediately:
  - state = HOLD, counter = 0.
  - `sys_reset` = 1, `cpu_reset` = 1, `boot` = 1, `cause` = 0, `busy` = 1.
- **Full request** = `mrst | kbd_rst | boot_done`.
  - Priority for `cause`: host > keyboard > boot_done.
  - In any state, a full request forces HOLD, clears the counter, sets both resets and updates `cause`.
  - A `boot_done` entry also clears `boot`. `boot` returns to 1 only via `_rst`.
- **HOLD**:
  - While a full request is present, the counter stays at 0.
  - Otherwise the counter increments on each `cnt` pulse.
  - When counter == `HOLD_TICKS`: go to PERIPH, clear the counter, `sys_reset` = 0.
- **PERIPH**:
  - The counter increments on `cnt`.
  - When counter == `CPU_DELAY`: go to RUN, `cpu_reset` = 0.
- **RUN**: `cpu_rst_instr` sends the block to INSTR, clears the counter and sets `sys_reset` = 1. `cpu_reset` stays 0.
- **INSTR**:
  - The counter increments on every `clk7_en`.
  - When counter == `INSTR_CYCLES` − 1: go to RUN, `sys_reset` = 0.
  - `cpu_rst_instr` in INSTR, HOLD or PERIPH is ignored.
  - `cause` is unchanged.
- Counter is 8 bits and saturates; it never wraps.
- `busy` = (state != RUN).

## Timing
- All outputs are registered.
- A request sampled at a `clk7_en` edge is reflected on the outputs right after that same edge (1-enable latency).
- `cnt` is only counted when coincident with `clk7_en`.
- Full request and `cnt` on the same enable: the request wins and the counter stays 0.
- Full request and `cpu_rst_instr` on the same enable: go to HOLD.
- Ordering guarantee: `sys_reset` always falls at least `CPU_DELAY` `cnt` ticks before `cpu_reset` after a full reset.
- Peripheral-only reset length: exactly `INSTR_CYCLES` `clk7_en` cycles of `sys_reset` high.
- `_rst` mid-sequence: abort and return to the `_rst` values; `boot` is set again.

## Structure
- Package `minimig_reset_pkg` holds:
  - the state encoding (HOLD, PERIPH, RUN, INSTR);
  - the `cause` encodings (CAUSE_POR, CAUSE_HOST, CAUSE_KBD, CAUSE_BOOT);
  - the parameter defaults.
- No sub-module: one FSM plus one shared 8-bit counter in a single module.

## Test plan
- Power-on: `_rst` low then high, `cnt` every 8 enables → `sys_reset` falls after the 4th `cnt`, `cpu_reset` after the 6th, `boot` = 1, `cause` = 0.
- Host reset: from RUN, `mrst` high for 10 `cnt` ticks then low → both resets held for all 10 ticks, `sys_reset` falls 4 `cnt` after `mrst` drops, `cause` = 1, `boot` unchanged.
- Boot done: `boot_done` pulse while `boot` = 1 → `boot` = 0 on the next enable, full sequence runs, `cause` = 3. A later `mrst` leaves `boot` = 0.
- RESET instruction: `cpu_rst_instr` pulse in RUN → `sys_reset` high for exactly 124 enables, `cpu_reset` stays 0. A second pulse during INSTR is ignored.
- Collisions:
  - `kbd_rst` arriving during INSTR → HOLD, `cpu_reset` = 1, `cause` = 2.
  - `mrst` and `kbd_rst` together → `cause` = 1.
  - `cnt` coincident with a request → counter stays 0.
- `_rst` asserted mid-PERIPH → all outputs return to their `_rst` values asynchronously, without waiting for `clk`.
